// File: rtl/cache_ctrl.sv
// Tag-store sequencing controller for a 4-way set-associative cache: lookup, true-LRU,
// dirty write-back, refill and hit/miss statistics. No data array is kept here.
//
// state     | meaning
// IDLE      | req_ready high, waiting for a request
// LOOKUP    | tag compare, counters, hit LRU/dirty update, victim choice
// WB_REQ    | presenting write-back of the dirty victim
// WB_WAIT   | waiting for write-back completion
// FILL_REQ  | presenting refill read of the requested block
// FILL_WAIT | waiting for refill, then installs the tag
// RESP      | one-cycle response pulse
module cache_ctrl #(
    parameter int A          = 4,
    parameter int N          = 256,
    parameter int ADD_SZ     = 16,
    parameter int TAG_SZ     = 7,
    parameter int IND_SZ     = 8,
    parameter int BLK_OFF_SZ = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADD_SZ-1:0] req_addr,
    input  logic              req_wr,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADD_SZ-1:0] mem_req_addr,
    output logic              mem_req_wr,
    input  logic              mem_done,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);
    localparam int WAY_SZ = $clog2(A);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP
    } state_t;

    typedef logic [A-1:0][WAY_SZ-1:0] age_row_t;

    function automatic age_row_t age_init();
        age_row_t r;
        for (int w = 0; w < A; w++) r[w] = WAY_SZ'(w);
        return r;
    endfunction

    localparam age_row_t AGE_ROW = age_init();

    state_t                       state;
    logic [TAG_SZ-1:0]            tag_mem [N][A];
    logic [N-1:0][A-1:0]          valid_mem;
    logic [N-1:0][A-1:0]          dirty_mem;
    logic [N-1:0][A-1:0][WAY_SZ-1:0] age_mem;

    logic [TAG_SZ-1:0] req_tag;
    logic [IND_SZ-1:0] req_idx;
    logic              wr_q;
    logic [WAY_SZ-1:0] victim_q;

    logic              hit_c;
    logic              inv_found_c;
    logic [WAY_SZ-1:0] hit_way_c;
    logic [WAY_SZ-1:0] victim_c;
    logic [WAY_SZ-1:0] lru_way_c;
    logic [WAY_SZ-1:0] old_age_c;
    age_row_t          cur_age_c;
    age_row_t          age_next_c;
    logic              unused_off;

    assign unused_off = ^req_addr[BLK_OFF_SZ-1:0];

    always_comb begin
        hit_c       = 1'b0;
        hit_way_c   = '0;
        inv_found_c = 1'b0;
        victim_c    = '0;
        cur_age_c   = age_mem[req_idx];
        for (int w = A-1; w >= 0; w--) begin
            if (valid_mem[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_SZ'(w);
            end
            if (!valid_mem[req_idx][w]) begin
                inv_found_c = 1'b1;
                victim_c    = WAY_SZ'(w);
            end
        end
        if (!inv_found_c) begin
            for (int w = 0; w < A; w++)
                if (cur_age_c[w] == WAY_SZ'(A-1)) victim_c = WAY_SZ'(w);
        end
        // The same age update serves a hit in LOOKUP and a fill in FILL_WAIT
        lru_way_c = (state == LOOKUP) ? hit_way_c : victim_q;
        old_age_c = cur_age_c[lru_way_c];
        for (int w = 0; w < A; w++) begin
            if (WAY_SZ'(w) == lru_way_c)     age_next_c[w] = '0;
            else if (cur_age_c[w] < old_age_c) age_next_c[w] = cur_age_c[w] + WAY_SZ'(1);
            else                             age_next_c[w] = cur_age_c[w];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_hit      <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wr    <= 1'b0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
            valid_mem     <= '0;
            dirty_mem     <= '0;
            age_mem       <= {N{AGE_ROW}};
            req_tag       <= '0;
            req_idx       <= '0;
            wr_q          <= 1'b0;
            victim_q      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    req_tag   <= req_addr[ADD_SZ-1 -: TAG_SZ];
                    req_idx   <= req_addr[BLK_OFF_SZ +: IND_SZ];
                    wr_q      <= req_wr;
                    req_ready <= 1'b0;
                    state     <= LOOKUP;
                end
                LOOKUP: begin
                    if (hit_c) begin
                        hit_cnt          <= hit_cnt + 32'd1;
                        age_mem[req_idx] <= age_next_c;
                        if (wr_q) dirty_mem[req_idx][hit_way_c] <= 1'b1;
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b1;
                        state      <= RESP;
                    end else begin
                        miss_cnt      <= miss_cnt + 32'd1;
                        victim_q      <= victim_c;
                        mem_req_valid <= 1'b1;
                        if (valid_mem[req_idx][victim_c] && dirty_mem[req_idx][victim_c]) begin
                            mem_req_wr   <= 1'b1;
                            mem_req_addr <= {tag_mem[req_idx][victim_c], req_idx, {BLK_OFF_SZ{1'b0}}};
                            state        <= WB_REQ;
                        end else begin
                            mem_req_wr   <= 1'b0;
                            mem_req_addr <= {req_tag, req_idx, {BLK_OFF_SZ{1'b0}}};
                            state        <= FILL_REQ;
                        end
                    end
                end
                WB_REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state         <= WB_WAIT;
                end
                WB_WAIT: if (mem_done) begin
                    mem_req_valid <= 1'b1;
                    mem_req_wr    <= 1'b0;
                    mem_req_addr  <= {req_tag, req_idx, {BLK_OFF_SZ{1'b0}}};
                    state         <= FILL_REQ;
                end
                FILL_REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state         <= FILL_WAIT;
                end
                FILL_WAIT: if (mem_done) begin
                    tag_mem[req_idx][victim_q]   <= req_tag;
                    valid_mem[req_idx][victim_q] <= 1'b1;
                    dirty_mem[req_idx][victim_q] <= wr_q;
                    age_mem[req_idx]             <= age_next_c;
                    resp_valid <= 1'b1;
                    resp_hit   <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_hit   <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: directed requests push expected responses and memory
// requests into queues; a monitor pops and compares them as the controller presents them.
module tb_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = '0;
    logic        req_wr = 1'b0;
    logic        resp_valid, resp_hit;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [15:0] mem_req_addr;
    logic        mem_req_wr;
    logic        mem_done = 1'b0;
    logic [31:0] hit_cnt, miss_cnt;

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wr(req_wr),
        .resp_valid(resp_valid), .resp_hit(resp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wr(mem_req_wr), .mem_done(mem_done),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic hit; logic [31:0] hc; logic [31:0] mc; int acc; } resp_t;
    typedef struct { logic [15:0] addr; logic wr; } mreq_t;
    resp_t resp_q[$];
    mreq_t mem_q[$];

    int checks = 0;
    int errors = 0;
    int resp_cnt = 0;
    logic [31:0] exp_hits = '0;
    logic [31:0] exp_misses = '0;

    int  hold_cfg = 0;
    int  done_delay = 1;
    bit  drop_done = 1'b0;
    int  phase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Memory model: optional ready stall, then mem_done a fixed delay after the handshake
    initial begin
        logic [15:0] cap_addr;
        logic        cap_wr;
        int          hold_left, delay_left;
        cap_addr = '0; cap_wr = 1'b0; hold_left = 0; delay_left = 0;
        forever begin
            @(posedge clk); #1;
            mem_done = 1'b0;
            if (rst) begin
                mem_req_ready = 1'b0;
                phase = 0;
            end else begin
                case (phase)
                    0: if (mem_req_valid) begin
                        cap_addr  = mem_req_addr;
                        cap_wr    = mem_req_wr;
                        hold_left = hold_cfg;
                        if (hold_left == 0) begin mem_req_ready = 1'b1; phase = 1; end
                        else phase = 2;
                    end
                    2: begin
                        check("hold_valid", {31'b0, mem_req_valid}, 1);
                        check("hold_addr", {16'b0, mem_req_addr}, {16'b0, cap_addr});
                        check("hold_wr", {31'b0, mem_req_wr}, {31'b0, cap_wr});
                        check("hold_req_ready", {31'b0, req_ready}, 0);
                        hold_left--;
                        if (hold_left == 0) begin mem_req_ready = 1'b1; phase = 1; end
                    end
                    1: begin
                        mem_req_ready = 1'b0;
                        delay_left = done_delay;
                        phase = 3;
                    end
                    3: if (delay_left == 0) begin
                        if (!drop_done) begin mem_done = 1'b1; phase = 0; end
                    end else delay_left--;
                    default: phase = 0;
                endcase
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        resp_t r;
        mreq_t m;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (resp_valid) begin
                    resp_cnt++;
                    if (resp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_resp: got hit=%0b expected none at cycle %0d", resp_hit, cyc);
                    end else begin
                        r = resp_q.pop_front();
                        check("resp_hit", {31'b0, resp_hit}, {31'b0, r.hit});
                        check("hit_cnt", hit_cnt, r.hc);
                        check("miss_cnt", miss_cnt, r.mc);
                        if (r.hit) check("hit_latency", 32'(cyc - r.acc), 2);
                    end
                end else begin
                    check("resp_hit_idle", {31'b0, resp_hit}, 0);
                end
                if (mem_req_valid && mem_req_ready) begin
                    if (mem_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_mem_req: got addr=0x%0h wr=%0b expected none", mem_req_addr, mem_req_wr);
                    end else begin
                        m = mem_q.pop_front();
                        check("mem_req_addr", {16'b0, mem_req_addr}, {16'b0, m.addr});
                        check("mem_req_wr", {31'b0, mem_req_wr}, {31'b0, m.wr});
                    end
                end
            end
        end
    end

    task automatic issue(input logic [15:0] addr, input logic wr, input logic exp_hit, input bit want_resp);
        int n;
        int base;
        n = 0;
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("req_ready_idle", {31'b0, req_ready}, 1);
        if (want_resp) begin
            if (exp_hit) exp_hits++; else exp_misses++;
            resp_q.push_back(resp_t'{exp_hit, exp_hits, exp_misses, cyc});
        end
        if (!exp_hit) mem_q.push_back(mreq_t'{addr & 16'hFFFE, 1'b0});
        base = resp_cnt;
        req_valid = 1'b1; req_addr = addr; req_wr = wr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (want_resp) begin
            n = 0;
            while (resp_cnt == base && n < 200) begin @(posedge clk); #1; n++; end
            if (resp_cnt == base) begin
                checks++; errors++;
                $display("FAIL resp_timeout: got no resp for addr 0x%0h expected one", addr);
            end
        end
    endtask

    task automatic push_wb(input logic [15:0] addr);
        mem_q.push_back(mreq_t'{addr, 1'b1});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_hits = '0; exp_misses = '0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_req_ready", {31'b0, req_ready}, 1);
        check("rst_resp_valid", {31'b0, resp_valid}, 0);
        check("rst_mem_req_valid", {31'b0, mem_req_valid}, 0);
        check("rst_mem_req_addr", {16'b0, mem_req_addr}, 0);
        check("rst_mem_req_wr", {31'b0, mem_req_wr}, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);

        // Cold miss, then hit in the same block
        issue(16'h0200, 1'b0, 1'b0, 1'b1);
        issue(16'h0201, 1'b0, 1'b1, 1'b1);
        // Fill set 0, then evict LRU way holding tag 0
        issue(16'h0000, 1'b0, 1'b0, 1'b1);
        issue(16'h0200, 1'b0, 1'b1, 1'b1);
        issue(16'h0400, 1'b0, 1'b0, 1'b1);
        issue(16'h0600, 1'b0, 1'b0, 1'b1);
        issue(16'h0800, 1'b0, 1'b0, 1'b1);
        issue(16'h0000, 1'b0, 1'b0, 1'b1);

        // Dirty eviction from a store miss
        do_reset();
        issue(16'h0000, 1'b1, 1'b0, 1'b1);
        issue(16'h0200, 1'b0, 1'b0, 1'b1);
        issue(16'h0400, 1'b0, 1'b0, 1'b1);
        issue(16'h0600, 1'b0, 1'b0, 1'b1);
        push_wb(16'h0000);
        issue(16'h0800, 1'b0, 1'b0, 1'b1);

        // Memory stalls ready for 5 cycles
        hold_cfg = 5;
        issue(16'h0A00, 1'b0, 1'b0, 1'b1);
        hold_cfg = 0;

        // Store hit marks the line dirty; it is written back when evicted later
        issue(16'h0401, 1'b1, 1'b1, 1'b1);
        issue(16'h0C00, 1'b0, 1'b0, 1'b1);
        issue(16'h0E00, 1'b0, 1'b0, 1'b1);
        issue(16'h1000, 1'b0, 1'b0, 1'b1);
        push_wb(16'h0400);
        issue(16'h1200, 1'b0, 1'b0, 1'b1);

        // Reset while waiting for the refill
        drop_done = 1'b1;
        issue(16'h1400, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (phase != 3 && n < 100) begin @(posedge clk); #1; n++; end
        check("reach_fill_wait", 32'(phase), 3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_hits = '0; exp_misses = '0;
        drop_done = 1'b0;
        check("midrst_req_ready", {31'b0, req_ready}, 1);
        check("midrst_mem_req_valid", {31'b0, mem_req_valid}, 0);
        check("midrst_resp_valid", {31'b0, resp_valid}, 0);
        check("midrst_hit_cnt", hit_cnt, 0);
        check("midrst_miss_cnt", miss_cnt, 0);
        repeat (5) @(posedge clk);
        #1;
        issue(16'h1401, 1'b0, 1'b0, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        check("mem_q_drained", 32'(mem_q.size()), 0);
        check("resp_q_drained", 32'(resp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
